// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b - bin one bit per clock through a
// single full-subtractor cell, with a start/busy/done handshake and registered results.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_rd;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_rd_next;
    logic             w_last;
    logic             w_accept;

    // Full-subtractor cell on the current LSBs plus the registered borrow.
    always_comb begin
        w_d       = r_ra[0] ^ r_rb[0] ^ r_br;
        w_br_next = (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_br);
        w_rd_next = r_rd >> 1;
        w_rd_next[WIDTH-1] = w_d;
        w_last    = (r_cnt == CW'(WIDTH - 1));
        w_accept  = start && ((r_state == StIdle) || (r_state == StDone));
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (start) w_state_next = StShift;
            StShift: if (w_last) w_state_next = StDone;
            StDone:  w_state_next = start ? StShift : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ra     <= '0;
            r_rb     <= '0;
            r_rd     <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_ra  <= a;
            r_rb  <= b;
            r_br  <= bin;
            r_cnt <= '0;
        end else if (r_state == StShift) begin
            r_ra  <= r_ra >> 1;
            r_rb  <= r_rb >> 1;
            r_br  <= w_br_next;
            r_rd  <= w_rd_next;
            r_cnt <= r_cnt + CW'(1);
            // Result registers update only on the final shift so they never show partials.
            if (w_last) begin
                r_diff   <= w_rd_next;
                r_borrow <= w_br_next;
            end
        end
    end

    assign busy   = (r_state == StShift);
    assign done   = (r_state == StDone);
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: drivers push expected {borrow,diff} into queues,
// per-instance monitors pop and compare on every done pulse (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       s8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       s1 = 1'b0, bin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, borrow1;
    logic [0:0] diff1;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         dones8   = 0;
    int         dones1   = 0;
    int         t_last8  = 0;
    int         t_prev8  = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [8:0] prev8 = '0;
    logic [1:0] prev1 = '0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        return {1'b0, a} - {1'b0, b} - {8'b0, bi};
    endfunction

    function automatic logic [1:0] ref1(input logic a, input logic b, input logic bi);
        return {1'b0, a} - {1'b0, b} - {1'b0, bi};
    endfunction

    // Monitors: compare on done, and flag result changes or busy/done overlap otherwise.
    always @(negedge clk) begin
        if (busy8 && done8) fail("busy_done_overlap8", 1, 0);
        if (!rst && !done8 && ({borrow8, diff8} !== prev8))
            fail("result_hold8", {borrow8, diff8}, prev8);
        prev8 = {borrow8, diff8};
        if (done8) begin
            dones8++;
            t_prev8 = t_last8;
            t_last8 = cyc;
            if (q8.size() == 0) fail("unexpected_done8", {borrow8, diff8}, 0);
            else check("result8", {borrow8, diff8}, q8.pop_front());
        end
    end

    always @(negedge clk) begin
        if (busy1 && done1) fail("busy_done_overlap1", 1, 0);
        if (!rst && !done1 && ({borrow1, diff1} !== prev1))
            fail("result_hold1", {borrow1, diff1}, prev1);
        prev1 = {borrow1, diff1};
        if (done1) begin
            dones1++;
            if (q1.size() == 0) fail("unexpected_done1", {borrow1, diff1}, 0);
            else check("result1", {borrow1, diff1}, q1.pop_front());
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [8:0] exp, input bit push);
        int n = 0;
        @(negedge clk);
        while (busy8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("ready_timeout8", n, 0);
        a8 = a; b8 = b; bin8 = bi; s8 = 1'b1;
        if (push) q8.push_back(exp);
        @(posedge clk);
        #1 s8 = 1'b0;
    endtask

    task automatic op1(input logic a, input logic b, input logic bi, input logic [1:0] exp);
        int n = 0;
        @(negedge clk);
        while (busy1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("ready_timeout1", n, 0);
        a1 = a; b1 = b; bin1 = bi; s1 = 1'b1;
        q1.push_back(exp);
        @(posedge clk);
        #1 s1 = 1'b0;
    endtask

    task automatic wait_idle(input bit wide);
        int n = 0;
        @(negedge clk);
        while ((wide ? (busy8 || done8) : (busy1 || done1)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("idle_timeout", n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         d0;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbi;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_diff", diff8, 0);
        check("reset_borrow", borrow8, 0);
        check("reset_diff1", {borrow1, diff1}, 0);

        // Basic operation with latency and pulse-width checks.
        op8(8'h5A, 8'h3C, 1'b0, 9'h01E, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy8) n++;
            else break;
        end
        check("busy_cycles", n, 8);
        check("done_pulse", done8, 1);
        @(negedge clk);
        check("done_drop", done8, 0);

        op8(8'h00, 8'h01, 1'b0, 9'h1FF, 1'b1);
        op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1);
        wait_idle(1'b1);

        // start and operand changes during SHIFT must be ignored.
        d0 = dones8;
        op8(8'h33, 8'h11, 1'b0, 9'h022, 1'b1);
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
        repeat (4) @(negedge clk);
        s8 = 1'b0;
        wait_idle(1'b1);
        check("single_done", dones8 - d0, 1);

        // Async reset three edges into SHIFT aborts without a done.
        d0 = dones8;
        op8(8'hC3, 8'h41, 1'b0, 9'h000, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_diff", diff8, 0);
        check("abort_borrow", borrow8, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", dones8 - d0, 0);
        op8(8'hC8, 8'h64, 1'b1, 9'h063, 1'b1);
        wait_idle(1'b1);

        // Back-to-back with start held high.
        d0 = dones8;
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
        q8.push_back(9'h07F);
        @(posedge clk);
        #1 a8 = 8'h10; b8 = 8'h10;
        q8.push_back(9'h000);
        repeat (9) @(posedge clk);
        #1 s8 = 1'b0;
        wait_idle(1'b1);
        check("b2b_count", dones8 - d0, 2);
        check("b2b_spacing", t_last8 - t_prev8, 9);

        // Corner operands for WIDTH=8.
        op8(8'h00, 8'h00, 1'b0, 9'h000, 1'b1);
        op8(8'h00, 8'h00, 1'b1, 9'h1FF, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0, 9'h000, 1'b1);
        op8(8'hFF, 8'h00, 1'b1, 9'h0FE, 1'b1);
        op8(8'h00, 8'hFF, 1'b0, 9'h101, 1'b1);
        for (int i = 0; i < 16; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom);
            op8(ra, rb, rbi, ref8(ra, rb, rbi), 1'b1);
        end

        // Exhaustive WIDTH=1 sweep.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0], ref1(v[2], v[1], v[0]));
        end

        wait_idle(1'b1);
        wait_idle(1'b0);
        check("queue8_drained", q8.size(), 0);
        check("queue1_drained", q1.size(), 0);
        check("dones1_total", dones1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
